uart_cmd_sequencer: RTL and testbench
=====================================

# uart_cmd_sequencer

Command sequencer behind the UART receive path. It takes the 9-bit frames produced by the UART processor, with their one-cycle valid strobe, and assembles fixed 5-byte command packets: header, address, data high, data low, XOR checksum. Each good packet becomes a held register-write request toward the VGA control registers. Malformed traffic is dropped with a one-cycle error report; the block never stalls the receiver.

## Interface
- `HEADER`, default 8'hA5: packet start byte.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum clk cycles allowed between consecutive bytes of one packet, range 2..2^24-1.
- `clk`, input, 1: system clock; all state on rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `frame`, input, 9: received frame; [7:0] data, [8] frame error flag (parity/stop error, 1 = bad).
- `frame_valid`, input, 1: one-cycle strobe, `frame` valid in that cycle; already in clk domain.
- `wr_req`, output, 1: write request, held until acknowledged.
- `wr_addr`, output, 8: register address; stable while `wr_req`=1.
- `wr_data`, output, 16: {data_hi, data_lo}; stable while `wr_req`=1.
- `wr_ack`, input, 1: sink accepts the write in any cycle where `wr_req`=1 and `wr_ack`=1.
- `err`, output, 1: one-cycle error pulse.
- `err_code`, output, 2: meaningful only when `err`=1. Codes:
  - 00: overrun
  - 01: frame error
  - 10: checksum
  - 11: timeout
- `busy`, output, 1: 1 in every state except IDLE.
- `pkt_count`, output, 8: count of acknowledged writes; wraps 255→0.

## Operation
- States: IDLE, ADDR, DHI, DLO, CHK, WRITE. All outputs are registered.
- IDLE: a valid frame with flag=0 and data==`HEADER` → ADDR. Any other valid frame is ignored silently, with no `err`.
- ADDR/DHI/DLO: each valid good frame latches its byte (addr, dhi, dlo) and advances ADDR→DHI→DLO→CHK.
- CHK: a valid good frame is compared with addr^dhi^dlo.
  - Match → WRITE, driving `wr_req`=1 with latched addr/data.
  - Mismatch → IDLE, `err`=1, code 10.
- Frame error: any valid frame with flag=1 in ADDR..CHK → IDLE, `err` code 01. The byte is discarded. A HEADER byte inside a packet is treated as ordinary data (no resync).
- Timeout: a 24-bit counter clears on entry to ADDR and on every valid frame in ADDR..CHK. Otherwise it increments while in ADDR..CHK. When it reaches `TIMEOUT_CYCLES`-1 with no frame that cycle → IDLE, `err` code 11.
- WRITE: hold `wr_req`, `wr_addr`, `wr_data` until `wr_ack`=1. On that edge:
  - `wr_req`→0
  - `pkt_count`+1
  - state → IDLE
- WRITE has no timeout.
- Overrun: a valid frame arriving in WRITE is dropped with `err` code 00, including when it coincides with `wr_ack`. The ack still completes.
- Simultaneous frame and timeout in the same cycle: the frame wins, the counter clears, and there is no timeout.
- Reset, asynchronous, at any time: all outputs 0, state IDLE, latched bytes 0, counter 0. A pending write is abandoned and is not counted.

## Timing
- A frame sampled at edge N sets state/`err`/`wr_req` visible after edge N. `wr_req` rises 1 cycle after the checksum byte's strobe.
- Minimum packet-to-write latency is 1 cycle after the 5th strobe. Back-to-back strobes on consecutive cycles must be accepted in ADDR..CHK.
- `err` is high for exactly one cycle per error event, and is 0 otherwise.
- An ack in the first `wr_req` cycle completes the write: `wr_req` is high for 1 cycle, and the block is back in IDLE the following cycle, ready for a header.
- `busy` deasserts on the same edge that `wr_req` falls.

## Test plan
- Good packet: A5,12,34,56,70 (12^34^56=70), ack 3 cycles after `wr_req` → `wr_addr`=12, `wr_data`=3456, `wr_req` high 3 cycles, `pkt_count`=1, `err` never set.
- Bad checksum: A5,01,02,03,FF → no `wr_req`; `err`=1 with code 10 one cycle after the last strobe; IDLE; next good packet is accepted.
- Frame error: A5,01 then {flag=1,02} → `err` code 01, IDLE. Bytes 03,00 that follow are ignored with no `err` (not HEADER).
- Timeout with `TIMEOUT_CYCLES`=16: A5,01 then silence → `err` code 11 exactly 16 cycles after the 01 strobe. A byte arriving on cycle 15 instead resets the window.
- Overrun: good packet, `wr_ack` held 0, then strobe 5A → `err` code 00. `wr_req` and `wr_addr`/`wr_data` unchanged; later ack → `pkt_count` increments.
- Reset mid-WRITE and wrap: `rst` low while `wr_req`=1 → all outputs 0 immediately. Separately, 256 acknowledged packets → `pkt_count` wraps to 0.

Source files
------------

// File: rtl/uart_cmd_sequencer.sv
// rtl/uart_cmd_sequencer.sv - assembles 5-byte UART command packets into held register-write requests
module uart_cmd_sequencer #(
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [8:0]  frame_i,
  input  logic        frame_valid_i,
  output logic        wr_req_o,
  output logic [7:0]  wr_addr_o,
  output logic [15:0] wr_data_o,
  input  logic        wr_ack_i,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic        busy_o,
  output logic [7:0]  pkt_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DHI,
    S_DLO,
    S_CHK,
    S_WRITE
  } state_e;

  localparam logic [1:0]  ERR_OVERRUN  = 2'b00;
  localparam logic [1:0]  ERR_FRAME    = 2'b01;
  localparam logic [1:0]  ERR_CHECKSUM = 2'b10;
  localparam logic [1:0]  ERR_TIMEOUT  = 2'b11;
  localparam logic [23:0] TCNT_LAST    = 24'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  addr_q;
  logic [7:0]  dhi_q;
  logic [7:0]  dlo_q;
  logic [23:0] tcnt_q;
  logic        wr_req_q;
  logic        err_q;
  logic [1:0]  err_code_q;
  logic        busy_q;
  logic [7:0]  pkt_count_q;

  logic       good_frame;
  logic [7:0] rx_byte;

  assign rx_byte    = frame_i[7:0];
  assign good_frame = frame_valid_i && !frame_i[8];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      dhi_q       <= '0;
      dlo_q       <= '0;
      tcnt_q      <= '0;
      wr_req_q    <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      busy_q      <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (good_frame && rx_byte == HEADER) begin
            state_q <= S_ADDR;
            busy_q  <= 1'b1;
            tcnt_q  <= '0;
          end
        end
        S_ADDR, S_DHI, S_DLO, S_CHK: begin
          // An arriving frame always beats a coinciding timeout.
          if (frame_valid_i) begin
            tcnt_q <= '0;
            if (frame_i[8]) begin
              state_q    <= S_IDLE;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
              err_code_q <= ERR_FRAME;
            end else begin
              case (state_q)
                S_ADDR: begin addr_q <= rx_byte; state_q <= S_DHI; end
                S_DHI:  begin dhi_q  <= rx_byte; state_q <= S_DLO; end
                S_DLO:  begin dlo_q  <= rx_byte; state_q <= S_CHK; end
                default: begin
                  if (rx_byte == (addr_q ^ dhi_q ^ dlo_q)) begin
                    state_q  <= S_WRITE;
                    wr_req_q <= 1'b1;
                  end else begin
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                    err_q      <= 1'b1;
                    err_code_q <= ERR_CHECKSUM;
                  end
                end
              endcase
            end
          end else if (tcnt_q == TCNT_LAST) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            tcnt_q     <= '0;
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
          end else begin
            tcnt_q <= tcnt_q + 24'd1;
          end
        end
        S_WRITE: begin
          // Frames here are dropped; a simultaneous ack still completes.
          if (frame_valid_i) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_OVERRUN;
          end
          if (wr_ack_i) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            wr_req_q    <= 1'b0;
            pkt_count_q <= pkt_count_q + 8'd1;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          wr_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign wr_req_o    = wr_req_q;
  assign wr_addr_o   = addr_q;
  assign wr_data_o   = {dhi_q, dlo_q};
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign busy_o      = busy_q;
  assign pkt_count_o = pkt_count_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb/tb_uart_cmd_sequencer.sv - directed self-checking bench for uart_cmd_sequencer
module tb_uart_cmd_sequencer;

  logic        clk;
  logic        rst_n;
  logic [8:0]  frame;
  logic        frame_valid;
  logic        wr_req;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;
  logic [7:0]  pkt_count;

  int n_checks = 0;
  int n_fails  = 0;
  logic [7:0] exp_pkt = 8'd0;

  uart_cmd_sequencer #(
    .HEADER(8'hA5),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .frame_i(frame),
    .frame_valid_i(frame_valid),
    .wr_req_o(wr_req),
    .wr_addr_o(wr_addr),
    .wr_data_o(wr_data),
    .wr_ack_i(wr_ack),
    .err_o(err),
    .err_code_o(err_code),
    .busy_o(busy),
    .pkt_count_o(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the sampling edge.
  task automatic send(input logic flag, input logic [7:0] b);
    frame       = {flag, b};
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic packet(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l);
    send(1'b0, 8'hA5);
    send(1'b0, a);
    send(1'b0, h);
    send(1'b0, l);
    send(1'b0, a ^ h ^ l);
  endtask

  task automatic all_outputs(output logic [63:0] v);
    v = {27'd0, wr_req, wr_addr, wr_data, err, err_code, busy, pkt_count};
  endtask

  initial begin
    logic [63:0] v;
    rst_n       = 1'b0;
    frame       = '0;
    frame_valid = 1'b0;
    wr_ack      = 1'b0;

    @(negedge clk);
    all_outputs(v);
    check("reset_outputs", v, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Good packet, ack on the third wr_req cycle
    send(1'b0, 8'hA5);
    check("good_busy_after_hdr", busy, 1'b1);
    send(1'b0, 8'h12);
    send(1'b0, 8'h34);
    send(1'b0, 8'h56);
    send(1'b0, 8'h70);
    check("good_wr_req_c1", wr_req, 1'b1);
    check("good_wr_addr", wr_addr, 8'h12);
    check("good_wr_data", wr_data, 16'h3456);
    check("good_no_err", err, 1'b0);
    wait_cycles(1);
    check("good_wr_req_c2", wr_req, 1'b1);
    wait_cycles(1);
    check("good_wr_req_c3", wr_req, 1'b1);
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    exp_pkt++;
    check("good_wr_req_fall", wr_req, 1'b0);
    check("good_busy_fall", busy, 1'b0);
    check("good_pkt_count", pkt_count, exp_pkt);

    // Bad checksum, then immediate-ack good packet
    packet(8'h01, 8'h02, 8'h03);
    check("badsum_wr_req_good_path", wr_req, 1'b1);
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    exp_pkt++;
    send(1'b0, 8'hA5);
    send(1'b0, 8'h01);
    send(1'b0, 8'h02);
    send(1'b0, 8'h03);
    send(1'b0, 8'hFF);
    check("badsum_err", err, 1'b1);
    check("badsum_code", err_code, 2'b10);
    check("badsum_no_wr_req", wr_req, 1'b0);
    check("badsum_idle", busy, 1'b0);
    wait_cycles(1);
    check("badsum_err_one_cycle", err, 1'b0);
    packet(8'hAA, 8'hBB, 8'hCC);
    check("after_bad_wr_req", wr_req, 1'b1);
    check("after_bad_data", wr_data, 16'hBBCC);
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    exp_pkt++;
    check("fast_ack_wr_req", wr_req, 1'b0);
    check("fast_ack_idle", busy, 1'b0);
    check("fast_ack_pkt", pkt_count, exp_pkt);

    // Frame error mid-packet; trailing bytes ignored
    send(1'b0, 8'hA5);
    send(1'b0, 8'h01);
    send(1'b1, 8'h02);
    check("ferr_err", err, 1'b1);
    check("ferr_code", err_code, 2'b01);
    check("ferr_idle", busy, 1'b0);
    send(1'b0, 8'h03);
    check("ferr_tail1_err", err, 1'b0);
    send(1'b0, 8'h00);
    check("ferr_tail2_err", err, 1'b0);
    check("ferr_tail_idle", busy, 1'b0);

    // Timeout exactly 16 cycles after the last strobe
    send(1'b0, 8'hA5);
    send(1'b0, 8'h01);
    wait_cycles(15);
    check("tmo_pre_err", err, 1'b0);
    check("tmo_pre_busy", busy, 1'b1);
    wait_cycles(1);
    check("tmo_err", err, 1'b1);
    check("tmo_code", err_code, 2'b11);
    check("tmo_idle", busy, 1'b0);
    wait_cycles(1);
    check("tmo_err_one_cycle", err, 1'b0);

    // Byte on cycle 15 restarts the window
    send(1'b0, 8'hA5);
    send(1'b0, 8'h01);
    wait_cycles(14);
    send(1'b0, 8'h02);
    check("tmo_rearm_err", err, 1'b0);
    check("tmo_rearm_busy", busy, 1'b1);
    wait_cycles(15);
    check("tmo_rearm_pre", err, 1'b0);
    wait_cycles(1);
    check("tmo_rearm_err2", err, 1'b1);
    check("tmo_rearm_code", err_code, 2'b11);

    // Frame coinciding with the timeout cycle wins
    send(1'b0, 8'hA5);
    send(1'b0, 8'h01);
    wait_cycles(15);
    send(1'b0, 8'h02);
    check("tmo_tie_err", err, 1'b0);
    check("tmo_tie_busy", busy, 1'b1);
    wait_cycles(20);
    check("tmo_tie_flushed", busy, 1'b0);

    // Overrun while holding the write
    packet(8'h21, 8'h43, 8'h65);
    check("ovr_wr_req", wr_req, 1'b1);
    wait_cycles(1);
    send(1'b0, 8'h5A);
    check("ovr_err", err, 1'b1);
    check("ovr_code", err_code, 2'b00);
    check("ovr_wr_req_held", wr_req, 1'b1);
    check("ovr_addr_held", wr_addr, 8'h21);
    check("ovr_data_held", wr_data, 16'h4365);
    wait_cycles(1);
    check("ovr_err_one_cycle", err, 1'b0);
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    exp_pkt++;
    check("ovr_pkt", pkt_count, exp_pkt);

    // Overrun coinciding with ack
    packet(8'h10, 8'h20, 8'h30);
    frame       = {1'b0, 8'h5A};
    frame_valid = 1'b1;
    wr_ack      = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    wr_ack      = 1'b0;
    exp_pkt++;
    check("ovr_ack_err", err, 1'b1);
    check("ovr_ack_code", err_code, 2'b00);
    check("ovr_ack_wr_req", wr_req, 1'b0);
    check("ovr_ack_pkt", pkt_count, exp_pkt);

    // Asynchronous reset while a write is pending
    packet(8'h77, 8'h88, 8'h99);
    check("rst_pre_wr_req", wr_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    all_outputs(v);
    check("rst_async_outputs", v, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pkt = 8'd0;
    @(negedge clk);

    // pkt_count wrap over 256 writes
    for (int i = 0; i < 256; i++) begin
      packet(8'(i), 8'h5C, 8'(255 - i));
      wr_ack = 1'b1;
      @(negedge clk);
      wr_ack = 1'b0;
      exp_pkt++;
      if (i == 254) check("wrap_255", pkt_count, 8'd255);
    end
    check("wrap_zero", pkt_count, 8'd0);
    check("wrap_model", pkt_count, exp_pkt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
